// File: rtl/uart_sched_pkg.sv
// Shared constants and frame helpers for the uart_tx frame scheduler.
// The header byte carries a sync nibble plus the channel index.
package uart_sched_pkg;

   localparam logic [1:0] ST_ARB       = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   localparam logic [3:0] SYNC_NIB_DEFAULT = 4'hA;

   localparam int FRAME_LEN_PLAIN = 3;
   localparam int FRAME_LEN_CSUM  = 4;

   typedef struct packed {
      logic [7:0] hdr;
      logic [7:0] msb;
      logic [7:0] lsb;
      logic [7:0] csum;
   } frame_t;

   function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
      return b0 ^ b1 ^ b2;
   endfunction

   function automatic logic [7:0] frame_byte(input frame_t f, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = f.hdr;
         2'd1:    b = f.msb;
         2'd2:    b = f.lsb;
         default: b = f.csum;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the registered pointer.
// The pointer only moves when the owner loads a new value.
module rr_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              ptr_load_i,
   input  logic [3:0]        ptr_next_i,
   output logic              gnt_valid_o,
   output logic [3:0]        gnt_idx_o
);

   logic [3:0]  ptr_q;
   logic [15:0] req_ext;
   logic [3:0]  cand_idx [NUM_CH];
   logic [NUM_CH-1:0] cand_req;

   assign req_ext = 16'(req_i);

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ptr_q <= 4'd0;
      end else if (ptr_load_i) begin
         ptr_q <= ptr_next_i;
      end
   end

   // Candidate gi is the channel gi positions after the pointer, wrapped.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      logic [4:0] sum;
      assign sum          = {1'b0, ptr_q} + 5'(gi);
      assign cand_idx[gi] = (sum >= 5'(NUM_CH)) ? 4'(sum - 5'(NUM_CH)) : sum[3:0];
      assign cand_req[gi] = req_ext[cand_idx[gi]];
   end

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = 4'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cand_req[i]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand_idx[i];
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx serializer among NUM_CH sample channels, sending
// header/MSB/LSB[/checksum] frames in round-robin channel order.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int         NUM_CH      = 4,
   parameter bit         CHECKSUM_EN = 1'b1,
   parameter logic [3:0] SYNC_NIB    = SYNC_NIB_DEFAULT
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Enable,
   input  logic [NUM_CH-1:0]    i_S_Valid,
   input  logic [16*NUM_CH-1:0] i_S_Data,
   output logic [NUM_CH-1:0]    o_S_Ready,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Ready,
   input  logic                 i_TX_Active,
   input  logic                 i_TX_Done,
   output logic                 o_Busy,
   output logic                 o_Frame_Done,
   output logic [3:0]           o_Frame_Ch
);

   localparam logic [1:0] LAST_IDX = CHECKSUM_EN ? 2'(FRAME_LEN_CSUM - 1)
                                                 : 2'(FRAME_LEN_PLAIN - 1);

   logic [1:0]        state_q, state_d;
   logic [NUM_CH-1:0] full_q, full_d;
   logic [NUM_CH-1:0] ready_q;
   logic [15:0]       sample_q [NUM_CH];
   frame_t            frame_q, frame_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [3:0]        ch_q, ch_d;
   logic              tx_dv_q, tx_dv_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              frame_done_q, frame_done_d;

   logic              gnt_valid;
   logic [3:0]        gnt_idx;
   logic              grant_fire;
   logic              ptr_load;
   logic [3:0]        ptr_next;
   logic [15:0]       gnt_sample;
   logic [NUM_CH-1:0] gnt_onehot;
   logic [NUM_CH-1:0] capture;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk_i       (i_Clock),
      .srst_i      (i_Reset),
      .req_i       (full_q),
      .ptr_load_i  (ptr_load),
      .ptr_next_i  (ptr_next),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   assign capture = i_S_Valid & ready_q;

   // Holding registers carry no reset; full_q alone says whether they hold data.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hold
      always_ff @(posedge i_Clock) begin
         if (capture[gi]) begin
            sample_q[gi] <= i_S_Data[16*gi +: 16];
         end
      end
   end

   always_comb begin
      gnt_sample = 16'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_idx == 4'(i)) begin
            gnt_sample = sample_q[i];
         end
      end
   end

   assign gnt_onehot = NUM_CH'(1) << gnt_idx;
   assign grant_fire = (state_q == ST_ARB) && i_Enable && gnt_valid && !i_TX_Active;
   assign ptr_next   = (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      full_d       = full_q | capture;
      frame_d      = frame_q;
      byte_idx_d   = byte_idx_q;
      ch_d         = ch_q;
      tx_dv_d      = tx_dv_q;
      tx_byte_d    = tx_byte_q;
      frame_done_d = 1'b0;
      ptr_load     = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (grant_fire) begin
               full_d       = full_d & ~gnt_onehot;
               frame_d.hdr  = {SYNC_NIB, gnt_idx};
               frame_d.msb  = gnt_sample[15:8];
               frame_d.lsb  = gnt_sample[7:0];
               frame_d.csum = frame_checksum({SYNC_NIB, gnt_idx}, gnt_sample[15:8],
                                             gnt_sample[7:0]);
               ch_d         = gnt_idx;
               byte_idx_d   = 2'd0;
               tx_dv_d      = 1'b1;
               tx_byte_d    = {SYNC_NIB, gnt_idx};
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Done pulses landing here are the tail of the previous byte.
            if (i_TX_Ready) begin
               tx_dv_d = 1'b0;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (i_TX_Done) begin
               if (byte_idx_q < LAST_IDX) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  tx_byte_d  = frame_byte(frame_q, byte_idx_d);
                  tx_dv_d    = 1'b1;
                  state_d    = ST_ISSUE;
               end else begin
                  frame_done_d = 1'b1;
                  ptr_load     = 1'b1;
                  state_d      = ST_ARB;
               end
            end
         end
         default: begin
            state_d = ST_ARB;
            tx_dv_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q      <= ST_ARB;
         full_q       <= '0;
         ready_q      <= '0;
         frame_q      <= '0;
         byte_idx_q   <= 2'd0;
         ch_q         <= 4'd0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= 8'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         ready_q      <= ~full_d;
         frame_q      <= frame_d;
         byte_idx_q   <= byte_idx_d;
         ch_q         <= ch_d;
         tx_dv_q      <= tx_dv_d;
         tx_byte_q    <= tx_byte_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_S_Ready    = ready_q;
   assign o_TX_DV      = tx_dv_q;
   assign o_TX_Byte    = tx_byte_q;
   assign o_Busy       = (state_q != ST_ARB);
   assign o_Frame_Done = frame_done_q;
   assign o_Frame_Ch   = ch_q;

endmodule
